slow_clk_monitor: RTL and testbench

- Receive-side companion to the system clock divider.
- Takes a divided/slow clock signal (or any slow square wave) into the 100 MHz system domain and synchronizes it.
- Emits single-cycle rise/fall enable pulses, measures the period in system-clock cycles, and flags lock or loss of the slow clock.
- Lets downstream game FSMs run on clean clock enables instead of a derived clock.

---
 rtl/slow_clk_monitor.sv | 184 ++++++++++++++++++
 tb/tb_slow_clk_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
//   Brings a slow square wave (typically the output of the system clock
//   divider) into the clk domain. It produces one-cycle rise/fall enables,
//   measures the rise-to-rise period in clk cycles, and reports whether the
//   period is stable (locked) or the slow clock has stopped (clk_lost).
//
//   Optional feature: define SLOW_CLK_DUTY_MEAS_EN to also measure high_time,
//   the number of clk cycles from a rise to the following fall. Without the
//   macro, high_time is tied to 0 and no duty-cycle logic is built.
//
//   Handshake: there is none. rise_pulse, fall_pulse and period_valid are
//   single-cycle strobes with no back-pressure. period, locked, clk_lost and
//   high_time are levels that keep their value until the next update.
//
//   The FSM state is held in the 'state' signal so that checkers can bind
//   to it.

module slow_clk_monitor #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 4000000,
  parameter int TOL     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             clk_lost
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOST    = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Synchronizer and edge-detect history
  logic s0;
  logic s1;
  logic prev;
  logic rise;
  logic fall;

  // Measurement state
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_period;
  logic [CNT_W-1:0] diff;
  logic             period_match;
  logic             timeout_hit;
  logic             lost_entry;

  // Internal edges are seen one cycle before the registered pulses go out
  assign rise = s1 & ~prev;
  assign fall = ~s1 & prev;

  // Two-flop synchronizer, edge history, and registered edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      s0         <= 1'b0;
      s1         <= 1'b0;
      prev       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s0         <= slow_clk;
      s1         <= s0;
      prev       <= s1;
      rise_pulse <= rise;
      fall_pulse <= fall;
    end
  end

  // Absolute difference between the running count and the previous period
  always_comb begin
    diff = '0;
    if (cnt >= last_period) begin
      diff = cnt - last_period;
    end else begin
      diff = last_period - cnt;
    end
  end

  // last_period == 0 means there is no reference period yet (after a start
  // or after recovery), so a first period can never lock
  assign period_match = (diff <= TOL_C) && (last_period != '0);

  // A rise in the same cycle as the timeout wins, so loss is only declared
  // when there is no rise
  assign timeout_hit = (cnt == TIMEOUT_C) && !rise;
  assign lost_entry  = timeout_hit && (state != LOST);

  // Period measurement, lock and loss FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_period  <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      clk_lost     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A first rise only starts the measurement; no period exists yet
          if (rise) begin
            cnt   <= ONE_C;
            state <= MEASURE;
          end else if (timeout_hit) begin
            state    <= LOST;
            clk_lost <= 1'b1;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        MEASURE: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= ONE_C;
            locked       <= period_match;
            last_period  <= cnt;
          end else if (timeout_hit) begin
            state       <= LOST;
            clk_lost    <= 1'b1;
            locked      <= 1'b0;
            last_period <= '0;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        LOST: begin
          // cnt holds at TIMEOUT while the slow clock stays absent
          if (rise) begin
            clk_lost <= 1'b0;
            cnt      <= ONE_C;
            state    <= MEASURE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SLOW_CLK_DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] high_time_r;

  assign high_time = high_time_r;

  // High-time counter; it is bounded by cnt, so it cannot wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      high_time_r <= '0;
    end else begin
      if (rise) begin
        hcnt <= ONE_C;
      end else if (state == MEASURE) begin
        hcnt <= hcnt + ONE_C;
      end
      if (lost_entry) begin
        high_time_r <= '0;
      end else if (fall && (state == MEASURE)) begin
        high_time_r <= hcnt;
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Bench for slow_clk_monitor with TIMEOUT=50 and TOL=1.
// The driver records the expected period/locked value for every rise it
// drives, and the expected high_time for every fall. A monitor pops these
// entries when period_valid or fall_pulse fires.

module tb_slow_clk_monitor;

  localparam int CNT_W   = 26;
  localparam int TIMEOUT = 50;
  localparam int TOL     = 1;

  logic             clk;
  logic             rst;
  logic             slow_clk;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] high_time;
  logic             locked;
  logic             clk_lost;

  slow_clk_monitor #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .TOL     (TOL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .slow_clk     (slow_clk),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .high_time    (high_time),
    .locked       (locked),
    .clk_lost     (clk_lost)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [CNT_W:0]   exp_q[$];   // {locked, period}
  logic [CNT_W-1:0] ht_q[$];
  int n_checks    = 0;
  int n_errors    = 0;
  int drv_since   = 0;
  int m_started   = 0;
  int m_last      = 0;
  int n_rise_exp  = 0;
  int n_fall_exp  = 0;
  int n_lost_exp  = 0;
  int n_rise      = 0;
  int n_fall      = 0;
  int n_lost      = 0;
  int since       = 0;
  logic was_lost  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rise"},   32'(rise_pulse),   0);
    check({tag, "_fall"},   32'(fall_pulse),   0);
    check({tag, "_period"}, 32'(period),       0);
    check({tag, "_pv"},     32'(period_valid), 0);
    check({tag, "_high"},   32'(high_time),    0);
    check({tag, "_locked"}, 32'(locked),       0);
    check({tag, "_lost"},   32'(clk_lost),     0);
  endtask

  // Reference model: period = driven spacing between rises
  task automatic model_rise();
    int d;
    logic lk;
    if (m_started != 0) begin
      d  = (drv_since > m_last) ? drv_since - m_last : m_last - drv_since;
      lk = (m_last != 0) && (d <= TOL);
      exp_q.push_back({lk, CNT_W'(drv_since)});
      m_last = drv_since;
    end
    m_started = 1;
    drv_since = 0;
    n_rise_exp++;
  endtask

  task automatic model_fall();
`ifdef SLOW_CLK_DUTY_MEAS_EN
    ht_q.push_back(CNT_W'(drv_since));
`else
    ht_q.push_back('0);
`endif
    n_fall_exp++;
  endtask

  // Driver: hold slow_clk at v for n clk cycles (called at posedge + 1)
  task automatic set_level(input logic v, input int n);
    if (v && !slow_clk) model_rise();
    else if (!v && slow_clk) model_fall();
    slow_clk = v;
    repeat (n) begin
      @(posedge clk);
      #1;
      drv_since++;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      set_level(1'b1, h);
      set_level(1'b0, l);
    end
  endtask

  // Edge sampled first at edge N must pulse only after edge N+2
  task automatic latency_step(input logic v, input string tag);
    if (v) model_rise();
    else model_fall();
    slow_clk = v;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      drv_since++;
      @(negedge clk);
      check(tag, 32'(v ? rise_pulse : fall_pulse), 32'(i == 2));
    end
    @(posedge clk);
    #1;
    drv_since++;
  endtask

  task automatic hold_low(input int n);
    set_level(1'b0, n);
    m_started = 0;
    m_last    = 0;
    n_lost_exp++;
  endtask

  // Monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin
    logic [CNT_W:0] e;
    if (rst) begin
      was_lost = 1'b0;
      since    = 0;
    end else begin
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          check("pv_unexpected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("period", 32'(period), 32'(e[CNT_W-1:0]));
          check("locked", 32'(locked), 32'(e[CNT_W]));
        end
      end
      if (fall_pulse) begin
        n_fall++;
        if (ht_q.size() == 0) check("fall_unexpected", 32'(ht_q.size()), 1);
        else check("high_time", 32'(high_time), 32'(ht_q.pop_front()));
      end
      if (rise_pulse) begin
        n_rise++;
        if (was_lost) check("lost_clear", 32'(clk_lost), 0);
        since = 0;
      end else begin
        since++;
      end
      if (clk_lost && !was_lost) begin
        n_lost++;
        check("lost_delay", 32'(since), TIMEOUT);
        check("lost_locked", 32'(locked), 0);
      end
      was_lost = clk_lost;
    end
  end

  // Stimulus sequence
  initial begin
    rst      = 1'b1;
    slow_clk = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv_since = 0;

    // Startup: start-only rise, then period 10 unlocked, then locked
    wave(5, 5, 4);
    // Small drift within TOL, then a large jump, then stable again
    wave(5, 6, 3);
    wave(7, 7, 3);
    // Edge latency
    latency_step(1'b1, "rise_latency");
    latency_step(1'b0, "fall_latency");
    // Loss and recovery
    hold_low(60);
    wave(5, 5, 4);
    // Reset in the middle of a measurement (cnt = 7)
    set_level(1'b1, 5);
    set_level(1'b0, 4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    m_started = 0;
    m_last    = 0;
    @(posedge clk);
    #1;
    drv_since = 0;
    // Restart with 3 high / 7 low
    wave(3, 7, 4);
    // Random duty and period
    for (int i = 0; i < 8; i++) begin
      set_level(1'b1, $urandom_range(6, 2));
      set_level(1'b0, $urandom_range(6, 3));
    end
    set_level(1'b0, 10);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("ht_q_drained", 32'(ht_q.size()), 0);
    check("rise_count", 32'(n_rise), 32'(n_rise_exp));
    check("fall_count", 32'(n_fall), 32'(n_fall_exp));
    check("lost_count", 32'(n_lost), 32'(n_lost_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
